seq_det_arbiter: RTL and testbench
==================================

# seq_det_arbiter

Shares one serial sequence-detector FSM between NREQ requesters, each streaming fixed-length bit frames. Grants are round-robin, one whole frame at a time. Before each frame the arbiter clears the detector, then drives the granted requester's bits into it. It samples the detector output every frame bit and reports a per-frame hit flag and hit count tagged with the requester id. Sits between the serial input channels and the single shared detector instance.

## Interface
- NREQ, 4, number of requesters (2–8)
- FRAME_LEN, 16, bits per frame (≥1)
- CNT_W, 8, width of hit_cnt
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- req  in  NREQ  requester has a frame ready; sampled only in IDLE
- bit_in  in  NREQ  serial data per requester; valid each cycle its gnt is high
- gnt  out  NREQ  one-hot; high for exactly FRAME_LEN cycles per frame; requester presents next bit each gnt cycle
- det_rst  out  1  synchronous active-high clear to detector
- det_seq  out  1  bit to detector
- det_out  in  1  detector Mealy output, combinational from detector state and det_seq
- frame_done  out  1  one-cycle pulse at frame end
- done_id  out  $clog2(NREQ)  requester id of the reported frame
- hit  out  1  det_out was 1 in at least one frame bit cycle
- hit_cnt  out  CNT_W  number of frame bit cycles with det_out=1, saturating

## Operation
- State machine: IDLE, CLEAR, STREAM, REPORT.
  - IDLE: if req≠0, pick the first set req at or after ptr (wrapping), latch it as id, go to CLEAR. Otherwise stay in IDLE.
  - CLEAR: det_rst=1 for one cycle; bit counter set to 0; hit accumulator cleared; go to STREAM.
  - STREAM: gnt[id]=1 and det_seq=bit_in[id]. Each cycle:
    - Sample det_out into the accumulator: hit_acc|=det_out; cnt_acc+=det_out, saturating at 2^CNT_W−1.
    - Increment the bit counter; after the cycle with count FRAME_LEN−1, go to REPORT.
  - REPORT: frame_done=1; load done_id, hit, hit_cnt from id and the accumulators; set ptr=(id+1) mod NREQ; go to IDLE.
- Outside STREAM: gnt=0, det_seq=0, det_out ignored.
- done_id, hit and hit_cnt hold their values until the next REPORT.
- Dropping req mid-frame has no effect; the frame always runs FRAME_LEN bits.
- Reset (rst=0, async): state=IDLE, ptr=0, id=0, counters 0. All outputs 0: gnt, det_rst, det_seq, frame_done, done_id, hit, hit_cnt. A frame interrupted by reset is discarded and not reported. The next frame starts with CLEAR, so detector state left by the aborted frame is irrelevant.

## Timing
- gnt, det_rst and frame_done decode from the state register (Moore).
- det_seq is a combinational mux of bit_in gated by STREAM.
- With req seen in IDLE at cycle T: CLEAR at T+1, STREAM T+2..T+1+FRAME_LEN, REPORT T+2+FRAME_LEN, IDLE T+3+FRAME_LEN.
- Per-frame overhead is 3 cycles. Back-to-back frames are separated by exactly one IDLE cycle.
- Arbitration happens only in IDLE; simultaneous reqs resolve by ptr order.
- det_out is sampled on the same edge that advances the detector, so the output for bit k is counted for bit k.

## Configuration
- SEQ_DET_ARB_HITCNT_EN defined: cnt_acc and hit_cnt are implemented as described.
- SEQ_DET_ARB_HITCNT_EN undefined: no counter is built; hit_cnt is tied to 0; hit, frame_done and done_id are unchanged.

## Structure
- Package seq_det_arb_pkg holds:
  - state typedef (IDLE=2'd0, CLEAR=2'd1, STREAM=2'd2, REPORT=2'd3)
  - default NREQ, FRAME_LEN and CNT_W constants
- Sub-module rr_pick: combinational round-robin picker. Inputs req and ptr; outputs valid and index.

## Test plan
- req=4'b0001, bit_in[0] stream 0,1,1 then 13 zeros (FRAME_LEN=16) -> frame_done at T+18, done_id=0, hit=1, hit_cnt=14.
- req=4'b0001, bit_in[0] all ones -> hit=0, hit_cnt=0; det_rst high exactly one cycle before the first gnt.
- req=4'b1111 held, from reset -> grant order 0,1,2,3,0; one IDLE cycle between consecutive REPORT and CLEAR.
- req[2] pulsed one cycle in IDLE, then dropped -> gnt[2] still high for 16 consecutive cycles; frame reported with done_id=2.
- rst low at the 5th STREAM cycle of requester 1 -> all outputs 0 immediately, no frame_done. After release with req=4'b0010, CLEAR precedes STREAM and ptr restarts at 0.
- SEQ_DET_ARB_HITCNT_EN undefined, rerun first scenario -> hit=1, hit_cnt=0.

Source files
------------

// File: rtl/seq_det_arb_pkg.sv
// seq_det_arb_pkg: shared state encoding and default sizing for the detector arbiter
package seq_det_arb_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, CLEAR = 2'd1, STREAM = 2'd2, REPORT = 2'd3} state_t;
  localparam int NREQ_D = 4;
  localparam int FRAME_LEN_D = 16;
  localparam int CNT_W_D = 8;
endpackage

// File: rtl/seq_det_arbiter_if.sv
// seq_det_arbiter_if: requester channels, shared-detector hookup and frame report bundle
interface seq_det_arbiter_if import seq_det_arb_pkg::*; #(
  parameter int NREQ = NREQ_D,
  parameter int CNT_W = CNT_W_D
);
  localparam int IW = $clog2(NREQ);
  logic [NREQ-1:0] req, bit_in, gnt;
  logic det_rst, det_seq, det_out, frame_done, hit;
  logic [IW-1:0] done_id;
  logic [CNT_W-1:0] hit_cnt;
  modport master (
    input req, bit_in, det_out,
    output gnt, det_rst, det_seq, frame_done, done_id, hit, hit_cnt
  );
  modport slave (
    output req, bit_in, det_out,
    input gnt, det_rst, det_seq, frame_done, done_id, hit, hit_cnt
  );
endinterface

// File: rtl/seq_det_arbiter_rr_pick.sv
// rr_pick: first set request at or after ptr, wrapping around
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic            valid,
  output logic [IW-1:0]   idx
);
  assign valid = |req;
  always_comb begin
    idx = '0;
    for (int k = NREQ - 1; k >= 0; k--)
      if (req[(int'(ptr) + k) % NREQ]) idx = IW'((int'(ptr) + k) % NREQ);
  end
endmodule

// File: rtl/seq_det_arbiter.sv
// seq_det_arbiter: round-robin sharing of one serial sequence detector across NREQ framed streams.
// Define SEQ_DET_ARB_HITCNT_EN to build the saturating per-frame hit counter (hit_cnt is 0 otherwise).
module seq_det_arbiter import seq_det_arb_pkg::*; #(
  parameter int NREQ = NREQ_D,
  parameter int FRAME_LEN = FRAME_LEN_D,
  parameter int CNT_W = CNT_W_D
) (
  input logic clk,
  input logic rst,
  seq_det_arbiter_if.master bus
);
  localparam int IW = $clog2(NREQ);
  localparam int BW = FRAME_LEN > 1 ? $clog2(FRAME_LEN) : 1;
  state_t state, nxt;
  logic [IW-1:0] ptr, id, pick;
  logic pick_v, last, hit_acc;
  logic [BW-1:0] bcnt;
  rr_pick #(.NREQ(NREQ)) u_pick (.req(bus.req), .ptr(ptr), .valid(pick_v), .idx(pick));
  assign last = state == STREAM && bcnt == BW'(FRAME_LEN - 1);
  always_comb begin
    nxt = state;
    nxt = state == IDLE ? (pick_v ? CLEAR : IDLE) :
          state == CLEAR ? STREAM :
          state == STREAM ? (last ? REPORT : STREAM) : IDLE;
  end
  assign bus.gnt = state == STREAM ? NREQ'(1) << id : '0;
  assign bus.det_rst = state == CLEAR;
  assign bus.frame_done = state == REPORT;
  assign bus.det_seq = state == STREAM && bus.bit_in[id];
  // report registers load on the final bit edge so they are valid alongside frame_done
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      ptr <= '0;
      id <= '0;
      bcnt <= '0;
      hit_acc <= 1'b0;
      bus.done_id <= '0;
      bus.hit <= 1'b0;
    end else begin
      state <= nxt;
      if (state == IDLE && pick_v) id <= pick;
      if (state == CLEAR) begin
        bcnt <= '0;
        hit_acc <= 1'b0;
      end
      if (state == STREAM) begin
        bcnt <= bcnt + 1'b1;
        hit_acc <= hit_acc | bus.det_out;
      end
      if (last) begin
        bus.done_id <= id;
        bus.hit <= hit_acc | bus.det_out;
        ptr <= id == IW'(NREQ - 1) ? '0 : id + 1'b1;
      end
    end
`ifdef SEQ_DET_ARB_HITCNT_EN
  logic [CNT_W-1:0] cnt_acc, cnt_n;
  assign cnt_n = &cnt_acc ? cnt_acc : cnt_acc + CNT_W'(bus.det_out);
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      cnt_acc <= '0;
      bus.hit_cnt <= '0;
    end else begin
      if (state == CLEAR) cnt_acc <= '0;
      if (state == STREAM) cnt_acc <= cnt_n;
      if (last) bus.hit_cnt <= cnt_n;
    end
`else
  assign bus.hit_cnt = '0;
`endif
endmodule

// File: tb/tb_seq_det_arbiter.sv
// tb_seq_det_arbiter: directed scenarios against a zero-bit detector model
module tb_seq_det_arbiter;
`ifdef SEQ_DET_ARB_HITCNT_EN
  localparam bit HC = 1'b1;
`else
  localparam bit HC = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [15:0] pat [4];
  logic [4:0] pos = '0;
  int checks = 0;
  int errors = 0;
  seq_det_arbiter_if #(.NREQ(4), .CNT_W(8)) bus ();
  seq_det_arbiter #(.NREQ(4), .FRAME_LEN(16), .CNT_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) pos <= |bus.gnt ? pos + 5'd1 : 5'd0;
  assign bus.bit_in = {pat[3][pos[3:0]], pat[2][pos[3:0]], pat[1][pos[3:0]], pat[0][pos[3:0]]};
  // detector flags every 0 bit it is fed
  assign bus.det_out = ~bus.det_seq;

  task automatic test_reset;
    rst = 1'b0;
    bus.req = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.gnt, bus.det_rst, bus.det_seq, bus.frame_done} !== 7'd0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 0", {bus.gnt, bus.det_rst, bus.det_seq, bus.frame_done});
    end
    checks++;
    if ({bus.done_id, bus.hit, bus.hit_cnt} !== 11'd0) begin
      errors++;
      $display("FAIL reset_report: got %b expected 0", {bus.done_id, bus.hit, bus.hit_cnt});
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.gnt, bus.det_rst} !== 5'd0) begin
      errors++;
      $display("FAIL idle_no_req: got %b expected 0", {bus.gnt, bus.det_rst});
    end
  endtask

  task automatic test_single_hit;
    int g = 0;
    int fd = 0;
    pat[0] = 16'h0006;
    bus.req = 4'b0001;
    for (int n = 1; n <= 19; n++) begin
      @(negedge clk);
      bus.req = '0;
      if (bus.gnt === 4'b0001) g++;
      if (bus.frame_done === 1'b1) fd++;
      if (n == 1) begin
        checks++;
        if (bus.det_rst !== 1'b1) begin errors++; $display("FAIL clear_pulse: got %b expected 1", bus.det_rst); end
      end
      if (n == 2) begin
        checks++;
        if (bus.det_seq !== 1'b0) begin errors++; $display("FAIL det_seq_bit0: got %b expected 0", bus.det_seq); end
      end
      if (n == 3) begin
        checks++;
        if (bus.det_seq !== 1'b1) begin errors++; $display("FAIL det_seq_bit1: got %b expected 1", bus.det_seq); end
      end
      if (n == 18) begin
        checks++;
        if (bus.frame_done !== 1'b1) begin errors++; $display("FAIL done_at_t18: got %b expected 1", bus.frame_done); end
        checks++;
        if (bus.done_id !== 2'd0) begin errors++; $display("FAIL hit_done_id: got %0d expected 0", bus.done_id); end
        checks++;
        if (bus.hit !== 1'b1) begin errors++; $display("FAIL hit_flag: got %b expected 1", bus.hit); end
        checks++;
        if (bus.hit_cnt !== (HC ? 8'd14 : 8'd0)) begin
          errors++;
          $display("FAIL hit_count: got %0d expected %0d", bus.hit_cnt, HC ? 14 : 0);
        end
      end
    end
    checks++;
    if (g != 16) begin errors++; $display("FAIL gnt_len: got %0d expected 16", g); end
    checks++;
    if (fd != 1) begin errors++; $display("FAIL done_pulses: got %0d expected 1", fd); end
  endtask

  task automatic test_all_ones;
    int dr = -1;
    int drc = 0;
    int g1 = -1;
    pat[0] = 16'hFFFF;
    bus.req = 4'b0001;
    for (int n = 1; n <= 19; n++) begin
      @(negedge clk);
      bus.req = '0;
      if (bus.det_rst === 1'b1) begin drc++; if (dr < 0) dr = n; end
      if (bus.gnt !== 4'b0000 && g1 < 0) g1 = n;
      if (n == 10) begin
        checks++;
        if (bus.det_seq !== 1'b1) begin errors++; $display("FAIL ones_det_seq: got %b expected 1", bus.det_seq); end
      end
      if (n == 18) begin
        checks++;
        if ({bus.hit, bus.hit_cnt} !== 9'd0) begin
          errors++;
          $display("FAIL ones_no_hit: got hit=%b cnt=%0d expected 0 0", bus.hit, bus.hit_cnt);
        end
      end
    end
    checks++;
    if (drc != 1 || g1 != dr + 1) begin
      errors++;
      $display("FAIL clear_before_gnt: got det_rst cycles=%0d at %0d gnt at %0d expected 1 cycle right before gnt", drc, dr, g1);
    end
  endtask

  task automatic test_round_robin;
    int ord[$];
    int gord[$];
    int exp_ord [5] = '{0, 1, 2, 3, 0};
    int last_fd = -1;
    logic [3:0] pg = '0;
    for (int i = 0; i < 4; i++) pat[i] = '0;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    bus.req = 4'b1111;
    for (int n = 1; n <= 95; n++) begin
      @(negedge clk);
      if (n == 95) bus.req = '0;
      if (bus.gnt !== 4'b0000 && pg === 4'b0000)
        for (int i = 0; i < 4; i++) if (bus.gnt[i]) gord.push_back(i);
      pg = bus.gnt;
      if (bus.det_rst === 1'b1 && last_fd >= 0) begin
        checks++;
        if (n - last_fd != 2) begin errors++; $display("FAIL b2b_gap: got %0d expected 2", n - last_fd); end
      end
      if (bus.frame_done === 1'b1) begin
        ord.push_back(int'(bus.done_id));
        last_fd = n;
      end
    end
    checks++;
    if (ord.size() != 5 || gord.size() != 5) begin
      errors++;
      $display("FAIL rr_frames: got %0d reports %0d grants expected 5 5", ord.size(), gord.size());
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (i >= ord.size() || i >= gord.size() || ord[i] != exp_ord[i] || gord[i] != exp_ord[i]) begin
        errors++;
        $display("FAIL rr_order[%0d]: got id=%0d gnt=%0d expected %0d", i,
                 i < ord.size() ? ord[i] : -1, i < gord.size() ? gord[i] : -1, exp_ord[i]);
      end
    end
  endtask

  task automatic test_req_pulse;
    int run = 0;
    int best = 0;
    int stray = 0;
    bus.req = 4'b0100;
    for (int n = 1; n <= 19; n++) begin
      @(negedge clk);
      bus.req = '0;
      if (bus.gnt === 4'b0100) begin run++; if (run > best) best = run; end
      else begin run = 0; if (bus.gnt !== 4'b0000) stray++; end
      if (n == 18) begin
        checks++;
        if (bus.frame_done !== 1'b1 || bus.done_id !== 2'd2) begin
          errors++;
          $display("FAIL pulse_report: got done=%b id=%0d expected 1 2", bus.frame_done, bus.done_id);
        end
      end
    end
    checks++;
    if (best != 16 || stray != 0) begin
      errors++;
      $display("FAIL pulse_gnt_run: got %0d stray=%0d expected 16 0", best, stray);
    end
  endtask

  task automatic test_reset_mid;
    int fd = 0;
    pat[1] = 16'h00F0;
    bus.req = 4'b0010;
    for (int n = 1; n <= 6; n++) begin
      @(negedge clk);
      bus.req = '0;
    end
    checks++;
    if (bus.gnt !== 4'b0010) begin errors++; $display("FAIL mid_gnt: got %b expected 0010", bus.gnt); end
    rst = 1'b0;
    #1;
    checks++;
    if ({bus.gnt, bus.det_rst, bus.det_seq, bus.frame_done, bus.done_id, bus.hit, bus.hit_cnt} !== 18'd0) begin
      errors++;
      $display("FAIL async_reset: got %b expected 0",
               {bus.gnt, bus.det_rst, bus.det_seq, bus.frame_done, bus.done_id, bus.hit, bus.hit_cnt});
    end
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      if (bus.frame_done === 1'b1) fd++;
    end
    rst = 1'b1;
    bus.req = 4'b1010;
    for (int n = 1; n <= 19; n++) begin
      @(negedge clk);
      bus.req = '0;
      if (bus.frame_done === 1'b1 && n != 18) fd++;
      if (n == 1) begin
        checks++;
        if (bus.det_rst !== 1'b1 || bus.gnt !== 4'b0000) begin
          errors++;
          $display("FAIL post_clear: got det_rst=%b gnt=%b expected 1 0000", bus.det_rst, bus.gnt);
        end
      end
      if (n == 2) begin
        checks++;
        if (bus.gnt !== 4'b0010) begin errors++; $display("FAIL ptr_restart: got %b expected 0010", bus.gnt); end
      end
      if (n == 18) begin
        checks++;
        if (bus.frame_done !== 1'b1 || bus.done_id !== 2'd1 || bus.hit !== 1'b1) begin
          errors++;
          $display("FAIL post_report: got done=%b id=%0d hit=%b expected 1 1 1", bus.frame_done, bus.done_id, bus.hit);
        end
        checks++;
        if (bus.hit_cnt !== (HC ? 8'd12 : 8'd0)) begin
          errors++;
          $display("FAIL post_count: got %0d expected %0d", bus.hit_cnt, HC ? 12 : 0);
        end
      end
    end
    checks++;
    if (fd != 0) begin errors++; $display("FAIL aborted_frame: got %0d stray frame_done expected 0", fd); end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) pat[i] = '0;
    bus.req = '0;
    test_reset;
    test_single_hit;
    test_all_ones;
    test_round_robin;
    test_req_pulse;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
